// File: rtl/apb_timer_pkg.sv
// ============================================================================
// Module      : apb_timer_pkg
// Description : Register offsets, CTRL bit positions and access-FSM encoding
//               shared by the APB timer front end and its timer core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_timer_pkg;

    // Word indices, i.e. PADDR[4:2]
    localparam logic [2:0] CTRL_OFF     = 3'd0;
    localparam logic [2:0] LOAD_OFF     = 3'd1;
    localparam logic [2:0] COUNT_OFF    = 3'd2;
    localparam logic [2:0] STATUS_OFF   = 3'd3;
    localparam logic [2:0] PRESCALE_OFF = 3'd4;

    localparam int CTRL_W        = 3;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_IE_BIT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } apb_state_t;

endpackage

`default_nettype wire

// File: rtl/apb_timer_slave_timer_core.sv
// ============================================================================
// Module      : timer_core
// Description : Prescaler, 32-bit down counter, reload and interrupt flag,
//               driven by decoded register write strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_core
    import apb_timer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ctrl_we,
    input  logic                  i_load_we,
    input  logic                  i_status_we,
    input  logic                  i_presc_we,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic [DATA_W-1:0]     o_load,
    output logic [DATA_W-1:0]     o_count,
    output logic                  o_if,
    output logic [PRESCALE_W-1:0] o_prescale,
    output logic                  o_irq
);

    logic [CTRL_W-1:0]     r_ctrl;
    logic [DATA_W-1:0]     r_load;
    logic [DATA_W-1:0]     r_count;
    logic                  r_if;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;

    logic w_en;
    logic w_auto;
    logic w_tick;
    logic w_expire;

    assign w_en     = r_ctrl[CTRL_EN_BIT];
    assign w_auto   = r_ctrl[CTRL_AUTO_BIT];
    // >= keeps the prescaler wrapping if PRESCALE is lowered below the count
    assign w_tick   = w_en && (r_pcnt >= r_prescale);
    assign w_expire = w_tick && (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_load     <= '0;
            r_count    <= '0;
            r_if       <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
        end else begin
            if (i_presc_we) begin
                r_prescale <= i_wdata[PRESCALE_W-1:0];
            end

            if (i_load_we) begin
                r_load  <= i_wdata;
                r_count <= i_wdata;
                r_pcnt  <= '0;
            end else begin
                if (w_en) begin
                    r_pcnt <= w_tick ? '0 : r_pcnt + PRESCALE_W'(1);
                end
                if (w_tick) begin
                    if (r_count != '0) begin
                        r_count <= r_count - DATA_W'(1);
                    end else if (w_auto) begin
                        r_count <= r_load;
                    end
                end
            end

            if (i_ctrl_we) begin
                r_ctrl <= i_wdata[CTRL_W-1:0];
            end else if (w_expire && !w_auto) begin
                r_ctrl[CTRL_EN_BIT] <= 1'b0;
            end

            // Hardware set beats a simultaneous write-1-to-clear
            if (w_expire) begin
                r_if <= 1'b1;
            end else if (i_status_we && i_wdata[0]) begin
                r_if <= 1'b0;
            end
        end
    end

    assign o_ctrl     = r_ctrl;
    assign o_load     = r_load;
    assign o_count    = r_count;
    assign o_if       = r_if;
    assign o_prescale = r_prescale;
    assign o_irq      = r_if && r_ctrl[CTRL_IE_BIT];

endmodule

`default_nettype wire

// File: rtl/apb_timer_slave.sv
// ============================================================================
// Module      : apb_timer_slave
// Description : APB completer front end for a prescaled down-counting timer.
//               Define TIMER_WAIT_STATE_EN for one wait state per access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR,
    output logic              IRQ
);

    apb_state_t r_state;
    apb_state_t w_state_nxt;

    logic [2:0]            w_idx;
    logic                  w_err;
    logic                  w_access;
    logic                  w_ready;
    logic                  w_commit;
    logic [DATA_W-1:0]     w_rd_live;
    logic [DATA_W-1:0]     w_rd_data;
    logic [CTRL_W-1:0]     w_ctrl;
    logic [DATA_W-1:0]     w_load;
    logic [DATA_W-1:0]     w_count;
    logic                  w_if;
    logic [PRESCALE_W-1:0] w_prescale;
    logic                  w_unused_paddr;

    assign w_unused_paddr = ^PADDR[ADDR_W-1:5];

    assign w_idx    = PADDR[4:2];
    assign w_err    = (PADDR[1:0] != 2'b00) || (w_idx > PRESCALE_OFF) ||
                      (PWRITE && (w_idx == COUNT_OFF));
    assign w_access = (r_state == ST_ACCESS) && PSEL && PENABLE;

`ifdef TIMER_WAIT_STATE_EN
    logic              r_waited;
    logic [DATA_W-1:0] r_rd_snap;

    // First access cycle is the wait state; read data is frozen on its edge
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_waited  <= 1'b0;
            r_rd_snap <= '0;
        end else begin
            r_waited <= w_access && !r_waited;
            if (w_access && !r_waited) begin
                r_rd_snap <= w_rd_live;
            end
        end
    end

    assign w_ready   = w_access && r_waited;
    assign w_rd_data = r_rd_snap;
`else
    assign w_ready   = w_access;
    assign w_rd_data = w_rd_live;
`endif

    assign w_commit = w_ready && PWRITE && !w_err;

    always_comb begin
        w_rd_live = '0;
        case (w_idx)
            CTRL_OFF:     w_rd_live = {{(DATA_W-CTRL_W){1'b0}}, w_ctrl};
            LOAD_OFF:     w_rd_live = w_load;
            COUNT_OFF:    w_rd_live = w_count;
            STATUS_OFF:   w_rd_live = {{(DATA_W-1){1'b0}}, w_if};
            PRESCALE_OFF: w_rd_live = {{(DATA_W-PRESCALE_W){1'b0}}, w_prescale};
            default:      w_rd_live = '0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!PSEL)        w_state_nxt = ST_IDLE;
                else if (w_ready) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = (PSEL && !PENABLE) ? ST_ACCESS : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && w_err;
    assign PRDATA  = (w_ready && !PWRITE && !w_err) ? w_rd_data : '0;

    timer_core #(
        .DATA_W     (DATA_W),
        .PRESCALE_W (PRESCALE_W)
    ) u_timer_core (
        .clk         (PCLK),
        .rst         (PRESET),
        .i_ctrl_we   (w_commit && (w_idx == CTRL_OFF)),
        .i_load_we   (w_commit && (w_idx == LOAD_OFF)),
        .i_status_we (w_commit && (w_idx == STATUS_OFF)),
        .i_presc_we  (w_commit && (w_idx == PRESCALE_OFF)),
        .i_wdata     (PWDATA),
        .o_ctrl      (w_ctrl),
        .o_load      (w_load),
        .o_count     (w_count),
        .o_if        (w_if),
        .o_prescale  (w_prescale),
        .o_irq       (IRQ)
    );

endmodule

`default_nettype wire

// File: tb/tb_apb_timer_slave.sv
// ============================================================================
// Module      : tb_apb_timer_slave
// Description : Scoreboarded APB bench for apb_timer_slave with a cycle model
//               of the timer; honours TIMER_WAIT_STATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_apb_timer_slave;

`ifdef TIMER_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;
    logic        IRQ;

    always #5 PCLK = ~PCLK;

    apb_timer_slave #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .PRESCALE_W (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR),
        .IRQ     (IRQ)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference timer model, stepped on every rising edge
    logic        m_en, m_auto, m_ie, m_if;
    logic [31:0] m_load, m_count;
    logic [15:0] m_presc, m_pcnt;
    logic        wr_ctrl = 0, wr_load = 0, wr_status = 0, wr_presc = 0;
    logic [31:0] wr_data = 0;
    wire         m_tick = m_en && (m_pcnt == m_presc);
    wire         m_exp  = m_tick && (m_count == 32'd0);

    always @(posedge PCLK) begin
        if (PRESET) begin
            m_en <= 0; m_auto <= 0; m_ie <= 0; m_if <= 0;
            m_load <= 0; m_count <= 0; m_presc <= 0; m_pcnt <= 0;
        end else begin
            if (wr_presc) m_presc <= wr_data[15:0];
            if (wr_load) begin
                m_load  <= wr_data;
                m_count <= wr_data;
                m_pcnt  <= 0;
            end else if (m_tick) begin
                m_pcnt <= 0;
                if (m_count != 0) m_count <= m_count - 1;
                else if (m_auto)  m_count <= m_load;
            end else if (m_en) begin
                m_pcnt <= m_pcnt + 1;
            end
            if (wr_ctrl) {m_ie, m_auto, m_en} <= wr_data[2:0];
            else if (m_exp && !m_auto) m_en <= 0;
            if (m_exp) m_if <= 1;
            else if (wr_status && wr_data[0]) m_if <= 0;
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return {29'd0, m_ie, m_auto, m_en};
            3'd1:    return m_load;
            3'd2:    return m_count;
            3'd3:    return {31'd0, m_if};
            3'd4:    return {16'd0, m_presc};
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard: {is_read, err, data} pushed when the access phase is driven
    string       sb_tag[$];
    logic [33:0] sb_val[$];

    logic mon_on = 1'b0;
    always @(negedge PCLK) begin
        if (mon_on) begin
            check("irq", IRQ, m_if & m_ie);
            if (PREADY !== 1'b1) begin
                check("idle_rdata", PRDATA, 32'd0);
                check("idle_err", PSLVERR, 1'b0);
            end
        end
    end

    // Entered and left just after a rising edge; back-to-back calls reuse the DONE cycle
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input string tag);
        logic        legal;
        logic [2:0]  idx;
        logic [33:0] v;
        string       t;
        int          waits;
        idx   = addr[4:2];
        legal = (addr[1:0] == 2'b00) && (idx <= 3'd4) && !(wr && idx == 3'd2);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1;
        sb_tag.push_back(tag);
        sb_val.push_back({!wr, !legal, legal ? model_read(idx) : 32'd0});
        waits = 0;
        @(negedge PCLK);
        while (PREADY !== 1'b1 && waits < 4) begin
            waits++;
            @(negedge PCLK);
        end
        t = sb_tag.pop_front();
        v = sb_val.pop_front();
        check({t, "_ready"}, PREADY, 1'b1);
        check({t, "_waits"}, waits, WS);
        check({t, "_slverr"}, PSLVERR, v[32]);
        if (v[33] || v[32]) check({t, "_rdata"}, PRDATA, v[31:0]);
        if (wr && legal && PREADY === 1'b1) begin
            wr_data   = wdata;
            wr_ctrl   = (idx == 3'd0);
            wr_load   = (idx == 3'd1);
            wr_status = (idx == 3'd3);
            wr_presc  = (idx == 3'd4);
        end
        @(posedge PCLK); #1;
        wr_ctrl = 0; wr_load = 0; wr_status = 0; wr_presc = 0;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        PRESET = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready", PREADY, 1'b0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pslverr", PSLVERR, 1'b0);
        check("rst_irq", IRQ, 1'b0);
        @(posedge PCLK); #1;
        PRESET = 0;
        mon_on = 1;

        for (int a = 0; a <= 16; a += 4) apb(0, a, 0, $sformatf("rst_rd%0h", a));

        // One-shot, prescale 0, interrupt enabled
        apb(1, 32'h04, 5, "ld5");
        apb(1, 32'h10, 0, "ps0");
        apb(1, 32'h00, 5, "ctrl5");
        for (int i = 0; i < 6; i++) apb(0, 32'h08, 0, $sformatf("cnt_a%0d", i));
        idle(4);
        apb(0, 32'h08, 0, "cnt_a_end");
        apb(0, 32'h0C, 0, "st_a");
        apb(0, 32'h00, 0, "ctrl_a");
        apb(1, 32'h0C, 1, "w1c_a");
        apb(0, 32'h0C, 0, "st_a_clr");

        // Auto-reload, prescale 2, interrupt disabled
        apb(1, 32'h10, 2, "ps2");
        apb(1, 32'h04, 3, "ld3");
        apb(1, 32'h00, 3, "ctrl3");
        for (int i = 0; i < 12; i++) apb(0, 32'h08, 0, $sformatf("cnt_b%0d", i));
        idle(25);
        apb(0, 32'h0C, 0, "st_b");
        apb(1, 32'h00, 0, "ctrl_off");
        apb(1, 32'h0C, 1, "w1c_b");

        // Illegal accesses leave state untouched
        apb(1, 32'h14, 32'hDEAD, "ill_w14");
        apb(0, 32'h14, 0, "ill_r14");
        apb(1, 32'h02, 7, "ill_wun");
        apb(0, 32'h06, 0, "ill_run");
        apb(1, 32'h08, 99, "ill_wcnt");
        apb(0, 32'h04, 0, "ill_ld_rb");
        apb(0, 32'h00, 0, "ill_ctrl_rb");
        apb(0, 32'h10, 0, "ill_ps_rb");

        // Setup then PSEL drop: no commit
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h04; PWDATA = 32'hBAD;
        @(posedge PCLK); #1;
        PSEL = 0;
        @(negedge PCLK);
        check("abort_pready", PREADY, 1'b0);
        @(posedge PCLK); #1;
        apb(0, 32'h04, 0, "abort_ld_rb");

        // W1C landing on the expiry edge
        apb(1, 32'h10, 0, "ps0_r");
        apb(1, 32'h04, 10, "ld10");
        apb(1, 32'h00, 5, "ctrl5_r");
        guard = 0;
        while (!(m_en && m_count == 32'(1 + WS)) && guard < 100) begin
            guard++;
            idle(1);
        end
        check("race_align", guard < 100, 1'b1);
        apb(1, 32'h0C, 1, "w1c_race");
        apb(0, 32'h0C, 0, "st_race");
        apb(1, 32'h0C, 1, "w1c_2");
        @(negedge PCLK);
        check("irq_drop", IRQ, 1'b0);
        @(posedge PCLK); #1;

        // Back-to-back write then read of LOAD
        apb(1, 32'h04, 32'h1234_5678, "b2b_w");
        apb(0, 32'h04, 0, "b2b_r");

        idle(2);
        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB completer (slave) holding a programmable 32-bit down-counting timer with prescaler, reload and interrupt.
- Sits on the same APB bus as the existing master and GPIO slave, on its own PSEL line.
- Answers master-initiated reads and writes with PREADY, PRDATA and PSLVERR.
- Raises a level interrupt when the timer expires.

Parameters:
- ADDR_W, 32, width of PADDR; only bits [4:2] are decoded.
- DATA_W, 32, width of PWDATA, PRDATA and all registers.
- PRESCALE_W, 16, width of the PRESCALE register.

Ports:
- PCLK  input  1  bus and timer clock
- PRESET  input  1  reset; synchronous, active-high
- PSEL  input  1  slave select from master
- PENABLE  input  1  APB access phase
- PWRITE  input  1  1=write, 0=read
- PADDR  input  ADDR_W  byte address
- PWDATA  input  DATA_W  write data
- PREADY  output  1  transfer completion
- PRDATA  output  DATA_W  read data, valid when PREADY=1 and PWRITE=0
- PSLVERR  output  1  error response, valid only when PREADY=1
- IRQ  output  1  timer interrupt, level

Behaviour:
- Reset (PRESET=1 at a PCLK edge) clears all registers, prescaler and FSM. PREADY, PRDATA, PSLVERR and IRQ all read 0.
- Reset mid-transfer abandons the transfer. No register update occurs.
- Register map, word offsets:
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IE; R/W.
  - 0x04 LOAD: R/W. A write also copies PWDATA into COUNT and clears the prescaler.
  - 0x08 COUNT: read-only.
  - 0x0C STATUS: bit0 IF; write-1-to-clear.
  - 0x10 PRESCALE: [PRESCALE_W-1:0] R/W; reads zero-extended.
- Illegal access: offset >0x10, unaligned PADDR[1:0]!=0, or a write to COUNT.
  - Completes with PSLVERR=1 and PRDATA=0.
  - Causes no state change.
- Access FSM states: IDLE, ACCESS, DONE.
  - IDLE->ACCESS when PSEL=1 and PENABLE=0 (setup).
  - ACCESS: PREADY=1 in the first cycle where PSEL and PENABLE are both 1. The register write commits on that edge. ACCESS->DONE.
  - DONE->IDLE, or DONE->ACCESS on back-to-back setup.
- PREADY, PRDATA and PSLVERR are 0 whenever PREADY would be 0.
- PSEL deasserting during ACCESS returns the FSM to IDLE with no commit.
- Prescaler, while EN=1:
  - Counts 0..PRESCALE, then wraps.
  - A wrap is one tick. PRESCALE=0 gives a tick every cycle.
- On a tick with COUNT!=0: COUNT decrements by 1.
- On a tick with COUNT==0:
  - IF is set.
  - If AUTO_RELOAD=1, COUNT reloads from LOAD.
  - Otherwise COUNT stays 0 and EN clears.
- EN=0 freezes both the prescaler and COUNT.
- IRQ = IF & IE, combinational from registers.
- Simultaneous events:
  - IF set by hardware in the same cycle as a STATUS W1C: set wins.
  - A LOAD write in the same cycle as a tick: the LOAD write wins.
  - A CTRL write clearing EN in the same cycle as expiry: IF is still set.
- All arithmetic is unsigned modulo 2^DATA_W. No underflow below 0.

Optional Feature:
- Macro TIMER_WAIT_STATE_EN.
- When defined:
  - ACCESS inserts exactly one wait state: PREADY=0 in the first access cycle and 1 in the second.
  - Reads return COUNT as sampled on the wait-state edge.
  - Writes commit on the PREADY=1 edge.
- When undefined: zero-wait behaviour as above.

Decomposition:
- Shared package apb_timer_pkg holds:
  - Register offset localparams (CTRL_OFF..PRESCALE_OFF).
  - CTRL bit-index constants.
  - FSM state encoding.
- One natural sub-module: timer_core (prescaler, COUNT, IF, reload logic). It receives decoded write strobes and data from the APB front end in apb_timer_slave.

Test Plan:
- Reset, then read offsets 0x00-0x10 -> all PRDATA=0, PSLVERR=0, IRQ=0.
- Write LOAD=5, PRESCALE=0, CTRL=0x5 -> COUNT reads 4,3,..0 on successive ticks. IF=1 and IRQ=1 on the tick after COUNT=0. EN clears; COUNT stays 0.
- LOAD=3, PRESCALE=2, CTRL=0x3 -> one decrement every 3 cycles. COUNT reloads to 3 after expiry. IF set every 12 cycles while IRQ stays 0 (IE=0).
- Write 0x14, unaligned 0x02, and a write to COUNT -> each returns PSLVERR=1. Register readback unchanged.
- STATUS W1C of IF issued in the exact expiry cycle -> IF remains 1. A second W1C clears it and IRQ drops next cycle.
- With TIMER_WAIT_STATE_EN defined -> every transfer shows PREADY=0 for one access cycle, then 1. Back-to-back write/read to LOAD returns the written value.
